dcp_noc_resp_deser: RTL and testbench

// Receive side of the DCP memory-request path: accepts NoC response packets (header flit + N payload flits)

---
 rtl/dcp_noc_resp_deser.sv | 112 +++++++++++
 tb/tb_dcp_noc_resp_deser.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcp_noc_resp_deser.sv
// Reassembles inbound NoC response packets (header + payload flits) into one response record.
// One packet in flight; the NoC is back-pressured only while a finished record waits.
module dcp_noc_resp_deser #(
    parameter int unsigned NOC_W          = 64,
    parameter int unsigned MSG_TYPE_W     = 8,
    parameter int unsigned MSHRID_W       = 8,
    parameter int unsigned MAX_DATA_FLITS = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              noc_val,
    input  logic [NOC_W-1:0]                  noc_dat,
    output logic                              noc_rdy,
    output logic                              resp_val,
    input  logic                              resp_rdy,
    output logic [MSG_TYPE_W-1:0]             resp_type,
    output logic [MSHRID_W-1:0]               resp_mshrid,
    output logic [7:0]                        resp_nflits,
    output logic [MAX_DATA_FLITS*NOC_W-1:0]   resp_data,
    output logic                              resp_err
);

    localparam int unsigned LenLsb    = 22;
    localparam int unsigned TypeLsb   = 14;
    localparam int unsigned MshridLsb = 6;

    typedef enum logic [1:0] {StHdr, StData, StOut} state_e;

    state_e                            state_q, state_d;
    logic [7:0]                        cnt_q, cnt_d;
    logic [7:0]                        nflits_q, nflits_d;
    logic [MSG_TYPE_W-1:0]             type_q, type_d;
    logic [MSHRID_W-1:0]               mshrid_q, mshrid_d;
    logic [MAX_DATA_FLITS*NOC_W-1:0]   data_q, data_d;
    logic                              err_q, err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StHdr;
            cnt_q    <= '0;
            nflits_q <= '0;
            type_q   <= '0;
            mshrid_q <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            nflits_q <= nflits_d;
            type_q   <= type_d;
            mshrid_q <= mshrid_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    // noc_rdy is 1 in StHdr/StData, so noc_val alone marks a handshake there.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        nflits_d = nflits_q;
        type_d   = type_q;
        mshrid_d = mshrid_q;
        data_d   = data_q;
        err_d    = err_q;
        unique case (state_q)
            StHdr: begin
                if (noc_val) begin
                    nflits_d = noc_dat[LenLsb +: 8];
                    type_d   = noc_dat[TypeLsb +: MSG_TYPE_W];
                    mshrid_d = noc_dat[MshridLsb +: MSHRID_W];
                    data_d   = '0;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = (noc_dat[LenLsb +: 8] == 8'd0) ? StOut : StData;
                end
            end
            StData: begin
                if (noc_val) begin
                    for (int unsigned k = 0; k < MAX_DATA_FLITS; k++) begin
                        if (cnt_q == 8'(k)) begin
                            data_d[k*NOC_W +: NOC_W] = noc_dat;
                        end
                    end
                    // Flits past the buffer are consumed but dropped.
                    if (cnt_q >= 8'(MAX_DATA_FLITS)) begin
                        err_d = 1'b1;
                    end
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == nflits_q - 8'd1) begin
                        state_d = StOut;
                    end
                end
            end
            StOut: begin
                if (resp_rdy) begin
                    state_d = StHdr;
                end
            end
            default: state_d = StHdr;
        endcase
    end

    assign noc_rdy     = (state_q != StOut);
    assign resp_val    = (state_q == StOut);
    assign resp_type   = type_q;
    assign resp_mshrid = mshrid_q;
    assign resp_nflits = nflits_q;
    assign resp_data   = data_q;
    assign resp_err    = err_q;

endmodule

// File: tb/tb_dcp_noc_resp_deser.sv
// Scoreboard bench: the driver pushes expected records built from packet rules, a negedge
// monitor pops and compares them whenever a response is presented.
module tb_dcp_noc_resp_deser;

    localparam int NOC_W = 64;
    localparam int MAXF  = 2;
    localparam int DW    = MAXF * NOC_W;

    logic            clk = 1'b0;
    logic            reset;
    logic            noc_val;
    logic [63:0]     noc_dat;
    logic            noc_rdy;
    logic            resp_val;
    logic            resp_rdy;
    logic [7:0]      resp_type;
    logic [7:0]      resp_mshrid;
    logic [7:0]      resp_nflits;
    logic [DW-1:0]   resp_data;
    logic            resp_err;

    dcp_noc_resp_deser dut (
        .clk         (clk),
        .reset       (reset),
        .noc_val     (noc_val),
        .noc_dat     (noc_dat),
        .noc_rdy     (noc_rdy),
        .resp_val    (resp_val),
        .resp_rdy    (resp_rdy),
        .resp_type   (resp_type),
        .resp_mshrid (resp_mshrid),
        .resp_nflits (resp_nflits),
        .resp_data   (resp_data),
        .resp_err    (resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]    tp;
        logic [7:0]    ms;
        logic [7:0]    n;
        logic [DW-1:0] d;
        logic          e;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rdy_mode = 0;  // 0: always ready, 1: random, 2: held low

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       resp_rdy = 1'b1;
            1:       resp_rdy = ($urandom_range(0, 3) != 0);
            default: resp_rdy = 1'b0;
        endcase
    end

    // Monitor
    initial begin
        bit   in_out = 0;
        bit   last_hs = 0;
        exp_t e;
        exp_t hold;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_out  = 0;
                last_hs = 0;
                continue;
            end
            chk("noc_rdy", DW'(noc_rdy), DW'(!resp_val));
            if (last_hs) chk("bubble", DW'(resp_val), '0);
            if (resp_val && !in_out) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got resp_val=1 expected no pending packet");
                end else begin
                    e = q.pop_front();
                    chk("resp_type", DW'(resp_type), DW'(e.tp));
                    chk("resp_mshrid", DW'(resp_mshrid), DW'(e.ms));
                    chk("resp_nflits", DW'(resp_nflits), DW'(e.n));
                    chk("resp_data", resp_data, e.d);
                    chk("resp_err", DW'(resp_err), DW'(e.e));
                    // resp_val must appear in the cycle right after the last flit handshake
                    chk("latency", DW'(cyc), DW'(e.cyc));
                end
                hold.tp = resp_type;
                hold.ms = resp_mshrid;
                hold.n  = resp_nflits;
                hold.d  = resp_data;
                hold.e  = resp_err;
                in_out  = 1;
            end else if (resp_val) begin
                chk("stable_type", DW'(resp_type), DW'(hold.tp));
                chk("stable_mshrid", DW'(resp_mshrid), DW'(hold.ms));
                chk("stable_nflits", DW'(resp_nflits), DW'(hold.n));
                chk("stable_data", resp_data, hold.d);
                chk("stable_err", DW'(resp_err), DW'(hold.e));
            end
            last_hs = resp_val && resp_rdy;
            if (last_hs || !resp_val) in_out = 0;
        end
    end

    task automatic send_flit(input logic [63:0] d, output int hc);
        logic r;
        int   n = 0;
        noc_val = 1'b1;
        noc_dat = d;
        forever begin
            @(negedge clk);
            r = noc_rdy;
            @(posedge clk);
            #1;
            if (r) break;
            n++;
            if (n > 300) begin
                $display("FAIL handshake_timeout: got no noc_rdy expected accept within 300 cycles");
                $fatal(1, "handshake timeout");
            end
        end
        noc_val = 1'b0;
        hc = cyc;
    endtask

    task automatic idle(input int g);
        repeat (g) begin
            @(posedge clk);
            #1;
        end
    endtask

    // gap < 0 selects a random 0..3 cycle gap before each payload flit
    task automatic send_pkt(input int len, input logic [7:0] tp, input logic [7:0] ms,
                            input logic [63:0] d0, input logic [63:0] d1, input int gap,
                            input bit stop_after_one);
        logic [63:0] h;
        logic [63:0] f;
        exp_t        e;
        int          hc;
        h        = {$urandom, $urandom};
        h[29:22] = 8'(len);
        h[21:14] = tp;
        h[13:6]  = ms;
        e.tp = tp;
        e.ms = ms;
        e.n  = 8'(len);
        e.e  = (len > MAXF);
        e.d  = '0;
        send_flit(h, hc);
        for (int k = 0; k < len; k++) begin
            idle(gap < 0 ? $urandom_range(0, 3) : gap);
            f = (k == 0) ? d0 : (k == 1) ? d1 : {$urandom, $urandom};
            if (k < MAXF) e.d[k*NOC_W +: NOC_W] = f;
            send_flit(f, hc);
            if (stop_after_one) return;
        end
        e.cyc = hc;
        q.push_back(e);
    endtask

    task automatic reset_checks();
        @(negedge clk);
        chk("rst_resp_val", DW'(resp_val), '0);
        chk("rst_noc_rdy", DW'(noc_rdy), DW'(1));
        chk("rst_type", DW'(resp_type), '0);
        chk("rst_mshrid", DW'(resp_mshrid), '0);
        chk("rst_nflits", DW'(resp_nflits), '0);
        chk("rst_data", resp_data, '0);
        chk("rst_err", DW'(resp_err), '0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || resp_val) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending responses expected 0", q.size());
        end
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        int          dummy;
        reset    = 1'b1;
        noc_val  = 1'b0;
        noc_dat  = '0;
        resp_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        reset_checks();

        a = {32'hAAAAAAAA, 32'hAAAAAAAA};
        b = {32'h55555555, 32'h55555555};
        send_pkt(0, 8'h0F, 8'h05, '0, '0, 0, 0);
        drain();
        send_pkt(2, 8'h11, 8'h22, a, b, 0, 0);
        drain();
        send_pkt(2, 8'h33, 8'h44, a, b, 3, 0);
        drain();

        // Held-off consumer: record must stay put and the NoC must stall
        rdy_mode = 2;
        send_pkt(1, 8'h66, 8'h77, a, b, 0, 0);
        idle(10);
        rdy_mode = 0;
        send_pkt(0, 8'h12, 8'h34, '0, '0, 0, 0);
        drain();

        send_pkt(4, 8'h81, 8'h92, b, a, 0, 0);
        drain();

        // Reset mid-packet drops the partial record
        send_pkt(2, 8'hA1, 8'hB2, a, b, 0, 1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        reset_checks();
        idle(3);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL reset_drop: got %0d pending expected 0", q.size());
        end
        send_pkt(2, 8'hC3, 8'hD4, b, a, 0, 0);
        drain();

        rdy_mode = 1;
        for (int i = 0; i < 150; i++) begin
            int len;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 12) : $urandom_range(0, 5);
            send_pkt(len, 8'($urandom), 8'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                     ($urandom_range(0, 1) != 0) ? 0 : -1, 0);
        end
        drain();
        rdy_mode = 0;
        dummy = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
